// File: rtl/shift_pipe_pkg.sv
// shift_pipe_pkg: shared types for the pipelined barrel shifter.
// Optional sticky tracking is enabled with SHIFT_PIPE_STICKY_EN.
package shift_pipe_pkg;

  typedef enum logic [1:0] {
    SRL = 2'd0,  // logical right
    SRA = 2'd1,  // arithmetic right
    SLL = 2'd2,  // logical left
    ROR = 2'd3   // rotate right
  } shift_mode_t;

  // Right shifts are the only modes that drop bits off the LSB end.
  function automatic logic drops_lsbs(shift_mode_t m);
    return (m == SRL) || (m == SRA);
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// shift_pipe_stage: one barrel-shifter mux layer (distance DIST, selected by
// shift bit SBIT) followed by its pipeline register. The LAST stage also
// folds in the top shift bit (distance >= WIDTH).
// Sticky tracking is present only with SHIFT_PIPE_STICKY_EN.
module shift_pipe_stage
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 6,
  parameter int DIST  = 1,
  parameter int SBIT  = 0,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  input  logic [SHW-1:0]   shift_i,
`ifdef SHIFT_PIPE_STICKY_EN
  input  logic             sticky_i,
  output logic             sticky_o,
`endif
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       mode_o,
  output logic [SHW-1:0]   shift_o
);

  shift_mode_t      mode;
  logic [WIDTH-1:0] shf, res;
  logic             vld_d, vld_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [1:0]       mode_d, mode_q;
  logic [SHW-1:0]   shift_d, shift_q;

  assign mode = shift_mode_t'(mode_i);

  // Mux layer, then the out-of-range correction in the final stage only.
  always_comb begin
    shf = data_i;
    if (shift_i[SBIT]) begin
      case (mode)
        SRL:     shf = data_i >> DIST;
        SRA:     shf = $signed(data_i) >>> DIST;
        SLL:     shf = data_i << DIST;
        default: shf = (data_i >> DIST) | (data_i << (WIDTH - DIST));
      endcase
    end
    res = shf;
    // Rotate is modulo WIDTH, so it ignores the top bit; the MSB is still
    // the original sign bit for SRA after any in-range shift.
    if (LAST && shift_i[SHW-1]) begin
      case (mode)
        SRL, SLL: res = '0;
        SRA:      res = {WIDTH{shf[WIDTH-1]}};
        default:  res = shf;
      endcase
    end
  end

  // All stages advance together on en; hold otherwise.
  always_comb begin
    vld_d   = en ? vld_i   : vld_q;
    data_d  = en ? res     : data_q;
    mode_d  = en ? mode_i  : mode_q;
    shift_d = en ? shift_i : shift_q;
  end

  // Stage register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      mode_q  <= 2'd0;
      shift_q <= '0;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
    end
  end

  assign vld_o   = vld_q;
  assign data_o  = data_q;
  assign mode_o  = mode_q;
  assign shift_o = shift_q;

`ifdef SHIFT_PIPE_STICKY_EN
  logic lost, sticky_n, sticky_d, sticky_q;

  // Accumulate bits dropped off the LSB end. For an out-of-range right shift
  // everything left in the word is lost too, which together with the bits
  // already dropped makes sticky equal to (in_data != 0).
  always_comb begin
    lost = 1'b0;
    if (shift_i[SBIT] && drops_lsbs(mode)) lost = |data_i[DIST-1:0];
    sticky_n = sticky_i | lost;
    if (LAST && shift_i[SHW-1] && drops_lsbs(mode)) sticky_n = sticky_n | (|shf);
    sticky_d = en ? sticky_n : sticky_q;
  end

  // Sticky stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_o = sticky_q;
`endif

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SRL/SRA/SLL/ROR), SHW-1 stages,
// one stage per shift bit, valid/ready handshake with whole-pipe stall.
// Define SHIFT_PIPE_STICKY_EN to add the out_sticky output and its stage bits.
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFT_PIPE_STICKY_EN
  output logic             out_sticky,
`endif
  output logic [WIDTH-1:0] out_data
);

  localparam int NST = SHW - 1;

  logic                       en;
  logic [NST:0]               vld_pipe;
  logic [NST:0][WIDTH-1:0]    data_s;
  logic [NST:0][1:0]          mode_s;
  logic [NST:0][SHW-1:0]      shift_s;
`ifdef SHIFT_PIPE_STICKY_EN
  logic [NST:0]               sticky_s;
  assign sticky_s[0] = 1'b0;
  assign out_sticky  = sticky_s[NST];
`endif

  // Single pipe-wide enable: empty output slot or downstream taking it.
  assign en       = !vld_pipe[NST] | out_ready;
  assign in_ready = en;

  assign vld_pipe[0] = in_valid;
  assign data_s[0]   = in_data;
  assign mode_s[0]   = in_mode;
  assign shift_s[0]  = in_shift;

  for (genvar k = 0; k < NST; k++) begin : g_stage
    shift_pipe_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .DIST  (1 << k),
      .SBIT  (k),
      .LAST  (k == NST - 1)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .vld_i    (vld_pipe[k]),
      .data_i   (data_s[k]),
      .mode_i   (mode_s[k]),
      .shift_i  (shift_s[k]),
`ifdef SHIFT_PIPE_STICKY_EN
      .sticky_i (sticky_s[k]),
      .sticky_o (sticky_s[k+1]),
`endif
      .vld_o    (vld_pipe[k+1]),
      .data_o   (data_s[k+1]),
      .mode_o   (mode_s[k+1]),
      .shift_o  (shift_s[k+1])
    );
  end

  assign out_valid = vld_pipe[NST];
  assign out_data  = data_s[NST];

  // Mode/shift are not needed past the last stage.
  logic unused_tail;
  assign unused_tail = ^{mode_s[NST], shift_s[NST]};

endmodule
